// File: rtl/load_unit.sv
// -----------------------------------------------------------------------------
// load_unit
//
// Load-side memory access unit for the single-cycle ARM datapath. It takes a
// load request, runs a request/acknowledge read against a variable-latency
// data memory, and returns the addressed byte, halfword or word, zero- or
// sign-extended for register writeback. While the memory read is
// outstanding, Stall holds the processor.
//
// Parameters
//   TIMEOUT     Number of unacknowledged REQ cycles tolerated before a bus
//               fault (1..255).
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   LoadStart   in   load instruction in execute (condition already applied)
//   LoadType    in   {Signed, Size[1:0]}: 00 byte, 01 half, 10/11 word
//   Addr        in   byte address of the load
//   Rd          in   destination register tag
//   Stall       out  hold PC and pipeline state
//   MemReq      out  memory read request (registered)
//   MemAddr     out  word-aligned read address
//   MemAck      in   MemRData valid this cycle
//   MemRData    in   read word, little-endian byte lanes
//   LoadDone    out  one-cycle pulse: LoadData/LoadRd valid
//   LoadData    out  extracted and extended load result
//   LoadRd      out  latched destination tag
//   AlignFault  out  one-cycle pulse: halfword load at an odd address
//   BusFault    out  one-cycle pulse: MemAck timeout
// -----------------------------------------------------------------------------
module load_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        LoadStart,
  input  logic [2:0]  LoadType,
  input  logic [31:0] Addr,
  input  logic [3:0]  Rd,
  output logic        Stall,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        LoadDone,
  output logic [31:0] LoadData,
  output logic [3:0]  LoadRd,
  output logic        AlignFault,
  output logic        BusFault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  logic [31:0] addr_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [7:0]  wait_cnt;

  // Lane extraction of the returned word.
  logic [5:0]  rot_sh;
  logic [63:0] dbl;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_data;

  // NOTE: every signal driven here gets a value on every path; a missing
  // assignment in a combinational block infers a latch.
  always_comb begin
    rot_sh = {1'b0, addr_q[1:0], 3'b000};
    // Doubling the word lets one part-select implement the ARMv4 rotate.
    dbl    = {MemRData, MemRData};
    byte_v = dbl[rot_sh +: 8];
    half_v = addr_q[1] ? MemRData[31:16] : MemRData[15:0];
    case (size_q)
      2'b00:   ext_data = {{24{signed_q & byte_v[7]}}, byte_v};
      2'b01:   ext_data = {{16{signed_q & half_v[15]}}, half_v};
      default: ext_data = dbl[rot_sh +: 32];
    endcase
  end

  assign MemAddr = {addr_q[31:2], 2'b00};

  // The start cycle stalls even when it heads to FAULT, so the processor
  // never advances past a load before its outcome is known.
  assign Stall = ((state == IDLE) && LoadStart) || (state == REQ);

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      signed_q   <= 1'b0;
      size_q     <= 2'b00;
      wait_cnt   <= '0;
      MemReq     <= 1'b0;
      LoadDone   <= 1'b0;
      LoadData   <= '0;
      LoadRd     <= '0;
      AlignFault <= 1'b0;
      BusFault   <= 1'b0;
    end else begin
      // Pulse outputs default low; set only on the transition that earns them.
      LoadDone   <= 1'b0;
      AlignFault <= 1'b0;
      BusFault   <= 1'b0;
      case (state)
        IDLE: begin
          if (LoadStart) begin
            addr_q   <= Addr;
            signed_q <= LoadType[2];
            size_q   <= LoadType[1:0];
            LoadRd   <= Rd;
            wait_cnt <= '0;
            if ((LoadType[1:0] == 2'b01) && Addr[0]) begin
              // Misaligned halfword: fault without touching memory.
              AlignFault <= 1'b1;
              state      <= FAULT;
            end else begin
              MemReq <= 1'b1;
              state  <= REQ;
            end
          end
        end
        REQ: begin
          if (MemAck) begin
            LoadData <= ext_data;
            LoadDone <= 1'b1;
            MemReq   <= 1'b0;
            state    <= DONE;
          end else if (wait_cnt == TIMEOUT_CNT) begin
            // TIMEOUT unacknowledged cycles already elapsed; give up.
            BusFault <= 1'b1;
            MemReq   <= 1'b0;
            state    <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// -----------------------------------------------------------------------------
// tb_load_unit
//
// Directed bench for load_unit. Each load is described by its type, address,
// returned data and ack delay; the expected cycle-by-cycle behaviour and the
// extracted result are derived from those with plain arithmetic, and a few
// loads also carry a hand-computed literal result.
// -----------------------------------------------------------------------------
module tb_load_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        LoadStart;
  logic [2:0]  LoadType;
  logic [31:0] Addr;
  logic [3:0]  Rd;
  logic        Stall;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemRData;
  logic        LoadDone;
  logic [31:0] LoadData;
  logic [3:0]  LoadRd;
  logic        AlignFault;
  logic        BusFault;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_data = 32'h0;  // last successfully loaded value

  load_unit #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .LoadStart  (LoadStart),
    .LoadType   (LoadType),
    .Addr       (Addr),
    .Rd         (Rd),
    .Stall      (Stall),
    .MemReq     (MemReq),
    .MemAddr    (MemAddr),
    .MemAck     (MemAck),
    .MemRData   (MemRData),
    .LoadDone   (LoadDone),
    .LoadData   (LoadData),
    .LoadRd     (LoadRd),
    .AlignFault (AlignFault),
    .BusFault   (BusFault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference extraction from the load rules, using shifts and masks.
  function automatic logic [31:0] ref_extract(input logic [2:0] t, input logic [31:0] a,
                                               input logic [31:0] d);
    int sh;
    logic [31:0] v;
    sh = 8 * int'(a[1:0]);
    case (t[1:0])
      2'b00: begin
        v = (d >> sh) & 32'h0000_00FF;
        if (t[2] && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'b01: begin
        v = a[1] ? (d >> 16) : (d & 32'h0000_FFFF);
        if (t[2] && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = (sh == 0) ? d : ((d >> sh) | (d << (32 - sh)));
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ctl(input string tag, input int c, input logic s, input logic r,
                         input logic dn, input logic af, input logic bf);
    check($sformatf("%s c%0d Stall", tag, c),      32'(Stall),      32'(s));
    check($sformatf("%s c%0d MemReq", tag, c),     32'(MemReq),     32'(r));
    check($sformatf("%s c%0d LoadDone", tag, c),   32'(LoadDone),   32'(dn));
    check($sformatf("%s c%0d AlignFault", tag, c), 32'(AlignFault), 32'(af));
    check($sformatf("%s c%0d BusFault", tag, c),   32'(BusFault),   32'(bf));
  endtask

  // One complete load. ack_delay < 0 means the memory never acknowledges.
  // Caller is positioned 1 time unit after a rising edge with the unit idle.
  task automatic run_load(input string tag, input logic [2:0] t, input logic [31:0] a,
                          input logic [3:0] rd, input logic [31:0] d, input int ack_delay,
                          input bit use_lit, input logic [31:0] lit);
    bit          align;
    int          req_cycles;
    int          last;
    logic [31:0] exp_data;
    align = (t[1:0] == 2'b01) && a[0];
    if (align)              req_cycles = 0;
    else if (ack_delay < 0) req_cycles = TO + 1;
    else                    req_cycles = ack_delay + 1;
    last     = 1 + req_cycles;
    exp_data = (align || ack_delay < 0) ? model_data : ref_extract(t, a, d);

    LoadStart = 1'b1;
    LoadType  = t;
    Addr      = a;
    Rd        = rd;
    MemAck    = 1'b0;
    MemRData  = 32'hDEAD_BEEF;
    #2;
    exp_ctl(tag, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int c = 1; c <= last; c++) begin
      tick();
      LoadStart = (c < last);
      MemAck    = (ack_delay >= 0) && (c == 1 + ack_delay);
      MemRData  = MemAck ? d : 32'hDEAD_BEEF;
      #2;
      if (c < last) begin
        exp_ctl(tag, c, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check($sformatf("%s c%0d MemAddr", tag, c), MemAddr, a & 32'hFFFF_FFFC);
      end else begin
        exp_ctl(tag, c, 1'b0, 1'b0, !align && ack_delay >= 0, align, !align && ack_delay < 0);
        check($sformatf("%s c%0d LoadData", tag, c), LoadData, exp_data);
        if (!align && ack_delay >= 0) begin
          check($sformatf("%s c%0d LoadRd", tag, c), 32'(LoadRd), 32'(rd));
          if (use_lit) check($sformatf("%s literal", tag), LoadData, lit);
        end
      end
    end
    model_data = exp_data;

    tick();
    MemAck   = 1'b0;
    MemRData = 32'hDEAD_BEEF;
    #2;
    exp_ctl({tag, " idle"}, last + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, " idle LoadData"}, LoadData, model_data);
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    exp_ctl(tag, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, " MemAddr"},  MemAddr,       32'h0);
    check({tag, " LoadData"}, LoadData,      32'h0);
    check({tag, " LoadRd"},   32'(LoadRd),   32'h0);
  endtask

  initial begin
    reset     = 1'b1;
    LoadStart = 1'b0;
    LoadType  = 3'b000;
    Addr      = 32'h0;
    Rd        = 4'h0;
    MemAck    = 1'b0;
    MemRData  = 32'h0;
    tick();
    tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();

    // LDRB signed, lane 3 = 0x80.
    run_load("ldrsb_1003", 3'b100, 32'h0000_1003, 4'h3, 32'h80FF_1234, 0, 1'b1, 32'hFFFF_FF80);
    // LDRH unsigned, upper half, ack after 3 cycles.
    run_load("ldrh_2002", 3'b001, 32'h0000_2002, 4'h7, 32'hBEEF_0011, 3, 1'b1, 32'h0000_BEEF);
    // LDR unaligned by one byte: rotate right 8.
    run_load("ldr_3001", 3'b010, 32'h0000_3001, 4'h1, 32'h4433_2211, 0, 1'b1, 32'h1144_3322);
    // LDRSH at odd address: alignment fault, no memory access.
    run_load("ldrsh_4001", 3'b101, 32'h0000_4001, 4'h2, 32'h5555_5555, 0, 1'b0, 32'h0);
    // No acknowledge: bus fault after TIMEOUT waiting cycles.
    run_load("ldr_timeout", 3'b010, 32'h0000_6004, 4'h4, 32'h0, -1, 1'b0, 32'h0);
    // Next load after a fault completes normally.
    run_load("ldrsh_7000", 3'b101, 32'h0000_7000, 4'h9, 32'h1234_8001, 0, 1'b1, 32'hFFFF_8001);
    run_load("ldrb_8001", 3'b000, 32'h0000_8001, 4'hA, 32'h00C3_A500, 1, 1'b1, 32'h0000_00A5);
    run_load("ldr_sz11", 3'b111, 32'h0000_9002, 4'hB, 32'hAABB_CCDD, 0, 1'b1, 32'hCCDD_AABB);
    run_load("ldrsb_pos", 3'b100, 32'h0000_A000, 4'hC, 32'hFFFF_FF7F, 2, 1'b1, 32'h0000_007F);
    run_load("ldr_b003", 3'b010, 32'h0000_B003, 4'hD, 32'h0102_0304, 0, 1'b1, 32'h0203_0401);

    // Reset in the middle of REQ, then a late acknowledge.
    LoadStart = 1'b1;
    LoadType  = 3'b010;
    Addr      = 32'h0000_5008;
    Rd        = 4'hE;
    tick();
    tick();
    #1;
    check("midreq MemReq before reset", 32'(MemReq), 32'h1);
    reset     = 1'b1;
    LoadStart = 1'b0;
    #1;
    check_reset_values("midreq reset");
    model_data = 32'h0;
    tick();
    reset = 1'b0;
    tick();
    MemAck   = 1'b1;
    MemRData = 32'h1234_5678;
    tick();
    MemAck = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      exp_ctl("late_ack", c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("late_ack c%0d LoadData", c), LoadData, model_data);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
